lsu_pipe: RTL
=============

LSU_PIPE -- requirements
Module: lsu_pipe

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the data path width; legal values are 32 and 64.
REQ-002 Parameter NB = XLEN/8, derived, SHALL set the number of byte lanes.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 ValidM  in  1  memory-stage instruction is valid.
REQ-006 MemReadM, MemWriteM  in  1 each  load / store request; never both set.
REQ-007 SizeM  in  2  access size: 0=byte, 1=half, 2=word, 3=double.
REQ-008 UnsignedM  in  1  zero-extend the load when 1, sign-extend when 0.
REQ-009 AddrM  in  XLEN  byte address, output of the ALU.
REQ-010 StoreDataM  in  XLEN  store data, held in the low lanes.
REQ-011 StallMem  out  1  holds the pipeline at or before M.
REQ-012 DoneM  out  1  one-cycle pulse marking access completion.
REQ-013 LoadDataM  out  XLEN  extended load data; valid only while DoneM=1 for a load.
REQ-014 MisalignM  out  1  one-cycle pulse for a misaligned or illegal access.
REQ-015 BusReqValid  out  1; BusReqReady  in  1  request handshake.
REQ-016 BusWrite  out  1; BusAddr  out  XLEN, NB-aligned; BusWData  out  XLEN; BusByteEn  out  NB.
REQ-017 BusRspValid  in  1; BusRData  in  XLEN  read response; stores receive no response.

Function
REQ-018 The FSM SHALL have three states, IDLE, REQ and WAIT, with one outstanding access at most.
REQ-019 An op is ValidM & (MemReadM | MemWriteM).
REQ-020 Aligned means AddrM mod 2^SizeM = 0; SizeM=3 with XLEN=32 is illegal.
REQ-021 IDLE with an aligned op SHALL register address, lane-shifted data, byte enables, size and sign, then go to REQ.
REQ-022 IDLE with an aligned op SHALL drive StallMem=1 combinationally in that same cycle.
REQ-023 IDLE with a misaligned or illegal op SHALL pulse MisalignM, issue no bus request, drive StallMem=0 and stay in IDLE.
REQ-024 In REQ, BusReqValid=1 and the payload SHALL stay stable until BusReqReady=1.
REQ-025 In REQ with BusReqReady=1 for a store, the block SHALL pulse DoneM, drive StallMem=0 and go to IDLE.
REQ-026 In REQ with BusReqReady=1 for a load, the block SHALL go to WAIT with StallMem=1.
REQ-027 In WAIT with BusRspValid=1, the block SHALL pulse DoneM, drive LoadDataM and StallMem=0, and go to IDLE.
REQ-028 In WAIT with BusRspValid=0, the block SHALL hold StallMem=1.
REQ-029 StallMem SHALL equal (IDLE & aligned op) | (REQ & ~(store & BusReqReady)) | (WAIT & ~BusRspValid).
REQ-030 Minimum latency SHALL be 2 cycles for a store and 3 cycles for a load, counted from the op seen in IDLE to DoneM.
REQ-031 BusRspValid in IDLE or REQ SHALL be ignored.
REQ-032 The cycle after DoneM is IDLE, so a back-to-back op SHALL be accepted there.
REQ-033 BusAddr SHALL be AddrM with the low log2(NB) bits cleared.
REQ-034 BusByteEn SHALL be ((1<<2^SizeM)-1) << offset, where offset = AddrM[log2(NB)-1:0].
REQ-035 BusWData SHALL be StoreDataM << (8*offset).
REQ-036 LoadDataM SHALL be BusRData >> (8*offset), truncated to 8·2^SizeM bits, then sign- or zero-extended to XLEN.
REQ-037 A word load at XLEN=32 SHALL ignore UnsignedM.

Reset
REQ-038 Asserting reset SHALL force, asynchronously: state=IDLE, BusReqValid=0, DoneM=0, MisalignM=0, StallMem=0, LoadDataM=0, and all payload registers 0.
REQ-039 Reset mid-access SHALL abandon the access; a response arriving after reset release SHALL be ignored.

Structure
REQ-040 Package lsu_pkg SHALL hold the size encodings (SZ_B, SZ_H, SZ_W, SZ_D) and the state enum.
REQ-041 Sub-module lsu_align SHALL contain the purely combinational lane shift, byte-enable generation and load extension, parameterised by XLEN.

Verification
REQ-042 XLEN=32, sb with AddrM=0x1003 and StoreDataM=0xAB, BusReqReady=1 -> BusAddr=0x1000, BusByteEn=4'b1000, BusWData=0xAB000000, DoneM two cycles after the op.
REQ-043 lh with AddrM=0x2002, BusRData=0x8001_0000, rsp 3 cycles late -> StallMem held through WAIT, LoadDataM=0xFFFF8001 with DoneM.
REQ-044 lhu with the same data -> LoadDataM=0x00008001.
REQ-045 lw with AddrM=0x3002 -> MisalignM pulse, BusReqValid stays 0, StallMem=0.
REQ-046 BusReqReady low for 4 cycles -> BusAddr, BusWData and BusByteEn stable, BusReqValid=1 throughout.
REQ-047 reset asserted in WAIT, then BusRspValid -> IDLE, no DoneM. XLEN=64 ld at 0x8 -> BusByteEn=8'hFF.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the alignment rule used to accept or reject a memory-stage access.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } lsu_state_e;

    // An access is aligned when the address is a multiple of its size.
    // Double accesses exist only on a 64-bit data path.
    function automatic logic lsu_is_aligned(
        input logic [2:0] addr_lo,
        input logic [1:0] size,
        input logic       has_double
    );
        logic ok;
        case (size)
            SZ_B:    ok = 1'b1;
            SZ_H:    ok = (addr_lo[0] == 1'b0);
            SZ_W:    ok = (addr_lo[1:0] == 2'b00);
            SZ_D:    ok = has_double & (addr_lo == 3'b000);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: store data shift and byte enables on the
// request side, load shift and sign/zero extension on the response side.
module lsu_align #(
    parameter  int XLEN = 32,
    localparam int NB   = XLEN / 8,
    localparam int OFFW = $clog2(XLEN / 8)
) (
    input  logic [OFFW-1:0] st_off,
    input  logic [1:0]      st_size,
    input  logic [XLEN-1:0] st_data,
    output logic [XLEN-1:0] st_wdata,
    output logic [NB-1:0]   st_be,
    input  logic [OFFW-1:0] ld_off,
    input  logic [1:0]      ld_size,
    input  logic            ld_unsigned,
    input  logic [XLEN-1:0] ld_rdata,
    output logic [XLEN-1:0] ld_data
);
    import lsu_pkg::*;

    logic [NB-1:0]   mask_s;
    logic [XLEN-1:0] shifted_s;
    logic [XLEN-1:0] keep_s;
    logic            sign_s;
    logic            fill_s;

    // Store side: size mask placed at the byte offset, data moved to its lanes.
    always_comb begin
        mask_s = '0;
        case (st_size)
            SZ_B:    mask_s = NB'(4'd1);
            SZ_H:    mask_s = NB'(4'd3);
            SZ_W:    mask_s = NB'(4'd15);
            SZ_D:    mask_s = {NB{1'b1}};
            default: mask_s = '0;
        endcase
        st_be    = mask_s << st_off;
        st_wdata = st_data << {st_off, 3'b000};
    end

    // Load side: bring the addressed lanes down, keep the access width and
    // fill the upper bits with the sign bit unless zero-extension is asked.
    // A full-width access keeps every bit, so extension has no effect there.
    always_comb begin
        shifted_s = ld_rdata >> {ld_off, 3'b000};
        keep_s    = '0;
        sign_s    = 1'b0;
        case (ld_size)
            SZ_B: begin
                keep_s = XLEN'(8'hFF);
                sign_s = shifted_s[7];
            end
            SZ_H: begin
                keep_s = XLEN'(16'hFFFF);
                sign_s = shifted_s[15];
            end
            SZ_W: begin
                keep_s = XLEN'(32'hFFFF_FFFF);
                sign_s = shifted_s[31];
            end
            SZ_D: begin
                keep_s = {XLEN{1'b1}};
                sign_s = shifted_s[XLEN-1];
            end
            default: begin
                keep_s = '0;
                sign_s = 1'b0;
            end
        endcase
        fill_s  = sign_s & ~ld_unsigned;
        ld_data = (shifted_s & keep_s) | ({XLEN{fill_s}} & ~keep_s);
    end

endmodule

// File: rtl/lsu_pipe.sv
// Memory-stage load/store unit: one outstanding bus access at a time,
// stalls the pipeline while busy, flags misaligned or illegal accesses.
module lsu_pipe #(
    parameter  int XLEN = 32,
    localparam int NB   = XLEN / 8,
    localparam int OFFW = $clog2(XLEN / 8)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ValidM,
    input  logic            MemReadM,
    input  logic            MemWriteM,
    input  logic [1:0]      SizeM,
    input  logic            UnsignedM,
    input  logic [XLEN-1:0] AddrM,
    input  logic [XLEN-1:0] StoreDataM,
    output logic            StallMem,
    output logic            DoneM,
    output logic [XLEN-1:0] LoadDataM,
    output logic            MisalignM,
    output logic            BusReqValid,
    input  logic            BusReqReady,
    output logic            BusWrite,
    output logic [XLEN-1:0] BusAddr,
    output logic [XLEN-1:0] BusWData,
    output logic [NB-1:0]   BusByteEn,
    input  logic            BusRspValid,
    input  logic [XLEN-1:0] BusRData
);
    import lsu_pkg::*;

    lsu_state_e      state_q, state_d;
    logic [XLEN-1:0] bus_addr_q, bus_addr_d;
    logic [XLEN-1:0] bus_wdata_q, bus_wdata_d;
    logic [NB-1:0]   bus_be_q, bus_be_d;
    logic            write_q, write_d;
    logic [1:0]      size_q, size_d;
    logic            unsigned_q, unsigned_d;
    logic [OFFW-1:0] off_q, off_d;
    logic            done_q, done_d;
    logic            misalign_q, misalign_d;
    logic [XLEN-1:0] ldata_q, ldata_d;

    logic            op_s;
    logic            aligned_s;
    logic            stall_s;
    logic [XLEN-1:0] st_wdata_s;
    logic [NB-1:0]   st_be_s;
    logic [XLEN-1:0] ld_data_s;

    assign op_s      = ValidM & (MemReadM | MemWriteM);
    assign aligned_s = lsu_is_aligned(AddrM[2:0], SizeM, (XLEN == 64));

    // Store lanes come from the live request; load extension uses the
    // offset, size and sign captured when the access was accepted.
    lsu_align #(
        .XLEN(XLEN)
    ) u_align (
        .st_off      (AddrM[OFFW-1:0]),
        .st_size     (SizeM),
        .st_data     (StoreDataM),
        .st_wdata    (st_wdata_s),
        .st_be       (st_be_s),
        .ld_off      (off_q),
        .ld_size     (size_q),
        .ld_unsigned (unsigned_q),
        .ld_rdata    (BusRData),
        .ld_data     (ld_data_s)
    );

    // Next-state, payload capture, completion pulses and pipeline stall.
    always_comb begin
        state_d     = state_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        write_d     = write_q;
        size_d      = size_q;
        unsigned_d  = unsigned_q;
        off_d       = off_q;
        ldata_d     = ldata_q;
        done_d      = 1'b0;
        misalign_d  = 1'b0;
        stall_s     = 1'b0;
        case (state_q)
            IDLE: begin
                if (op_s && aligned_s) begin
                    stall_s     = 1'b1;
                    state_d     = REQ;
                    bus_addr_d  = {AddrM[XLEN-1:OFFW], {OFFW{1'b0}}};
                    bus_wdata_d = MemWriteM ? st_wdata_s : '0;
                    bus_be_d    = st_be_s;
                    write_d     = MemWriteM;
                    size_d      = SizeM;
                    unsigned_d  = UnsignedM;
                    off_d       = AddrM[OFFW-1:0];
                end else if (op_s) begin
                    misalign_d  = 1'b1;
                end else begin
                    state_d     = IDLE;
                end
            end
            REQ: begin
                stall_s = ~(write_q & BusReqReady);
                if (BusReqReady) begin
                    if (write_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT;
                    end
                end else begin
                    state_d = REQ;
                end
            end
            WAIT: begin
                stall_s = ~BusRspValid;
                if (BusRspValid) begin
                    done_d  = 1'b1;
                    ldata_d = ld_data_s;
                    state_d = IDLE;
                end else begin
                    state_d = WAIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and payload registers; reset abandons any access in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_be_q    <= '0;
            write_q     <= 1'b0;
            size_q      <= 2'b00;
            unsigned_q  <= 1'b0;
            off_q       <= '0;
            done_q      <= 1'b0;
            misalign_q  <= 1'b0;
            ldata_q     <= '0;
        end else begin
            state_q     <= state_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
            write_q     <= write_d;
            size_q      <= size_d;
            unsigned_q  <= unsigned_d;
            off_q       <= off_d;
            done_q      <= done_d;
            misalign_q  <= misalign_d;
            ldata_q     <= ldata_d;
        end
    end

    assign StallMem    = stall_s & reset;
    assign DoneM       = done_q;
    assign MisalignM   = misalign_q;
    assign LoadDataM   = ldata_q;
    assign BusReqValid = (state_q == REQ);
    assign BusWrite    = write_q;
    assign BusAddr     = bus_addr_q;
    assign BusWData    = bus_wdata_q;
    assign BusByteEn   = bus_be_q;

endmodule
